// File: rtl/dpa_pkg.sv
// Shared definitions for the DPA pixel datapath: operation codes, photo-size codes
// and the default channel/counter widths.
package dpa_pkg;

   localparam logic [1:0] BYPASS = 2'b00;
   localparam logic [1:0] ADD    = 2'b01;
   localparam logic [1:0] SHIFT  = 2'b11;
   localparam logic [1:0] EXPAND = 2'b10;

   typedef enum logic [1:0] {
      NORMAL = 2'b00,
      SMALL  = 2'b01,
      LARGE  = 2'b11
   } photo_size_e;

   localparam int NCH_DEF  = 3;
   localparam int CW_DEF   = 8;
   localparam int AW_DEF   = 10;
   localparam int SW_DEF   = 2;
   localparam int CNTW_DEF = 20;

endpackage

// File: rtl/dpa_pix_lane.sv
// One colour channel of the S2 arithmetic: bypass / add / average / expand, computed at
// AW+1 bits and reduced to AW by wrapping, or by clamping when DPA_PIX_DP_SAT_EN is defined.
module dpa_pix_lane
   import dpa_pkg::*;
#(
   parameter int CW = CW_DEF,
   parameter int AW = AW_DEF,
   parameter int SW = SW_DEF
) (
   input  logic [1:0]    mode,
   input  logic [SW-1:0] sftr,
   input  logic [CW-1:0] pix,
   input  logic [AW-1:0] acc,
   output logic [AW-1:0] res
);

   logic [AW:0] p;
   logic [AW:0] sum;
`ifdef DPA_PIX_DP_SAT_EN
   logic [AW:0]   exp_v;
   logic [AW-1:0] sat_sum;
   logic [AW-1:0] sat_exp;
`endif

   // NOTE: res gets a default before the case so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      res = '0;
      p   = (AW+1)'(pix);
      sum = {1'b0, acc} + p;
`ifdef DPA_PIX_DP_SAT_EN
      exp_v   = p << sftr;
      sat_sum = sum[AW]   ? '1 : sum[AW-1:0];
      sat_exp = exp_v[AW] ? '1 : exp_v[AW-1:0];
      case (mode)
         BYPASS: res = AW'(pix);
         ADD:    res = sat_sum;
         SHIFT:  res = sat_sum >> sftr;   // clamp before the shift
         EXPAND: res = sat_exp;
      endcase
`else
      case (mode)
         BYPASS: res = AW'(pix);
         ADD:    res = sum[AW-1:0];
         SHIFT:  res = AW'(sum >> sftr);
         EXPAND: res = AW'(pix) << sftr;
      endcase
`endif
   end

endmodule

// File: rtl/dpa_pix_dp.sv
// Two-stage valid/ready pixel datapath with a per-frame output pixel counter.
// Optional saturation of ADD/SHIFT/EXPAND is enabled by defining DPA_PIX_DP_SAT_EN.
module dpa_pix_dp
   import dpa_pkg::*;
#(
   parameter int NCH  = NCH_DEF,
   parameter int CW   = CW_DEF,
   parameter int AW   = AW_DEF,
   parameter int SW   = SW_DEF,
   parameter int CNTW = CNTW_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [NCH*CW-1:0] in_pix,
   input  logic [NCH*AW-1:0] in_acc,
   input  logic [1:0]        in_mode,
   input  logic [SW-1:0]     in_sftr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [NCH*AW-1:0] out_pix,
   input  logic [CNTW-1:0]   frame_len,
   input  logic              clr,
   output logic [CNTW-1:0]   pix_cnt,
   output logic              frame_done
);

   logic              v1;
   logic              v2;
   logic [NCH*CW-1:0] pix1;
   logic [NCH*AW-1:0] acc1;
   logic [1:0]        mode1;
   logic [SW-1:0]     sftr1;
   logic [NCH*AW-1:0] res;
   logic              s2_adv;
   logic              in_hs;
   logic              out_hs;

   // in_ready depends only on registered valids and out_ready, never on in_valid.
   assign s2_adv    = !v2 || out_ready;
   assign in_ready  = !v1 || s2_adv;
   assign in_hs     = in_valid && in_ready;
   assign out_hs    = v2 && out_ready;
   assign out_valid = v2;

   // NOTE: S1 operands are reset together with v1 so no stale data survives a mid-stream reset.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v1    <= 1'b0;
         pix1  <= '0;
         acc1  <= '0;
         mode1 <= BYPASS;
         sftr1 <= '0;
      end else begin
         if (in_ready) v1 <= in_valid;
         if (in_hs) begin
            pix1  <= in_pix;
            acc1  <= in_acc;
            mode1 <= in_mode;
            sftr1 <= in_sftr;
         end
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_lane
      dpa_pix_lane #(
         .CW (CW),
         .AW (AW),
         .SW (SW)
      ) u_lane (
         .mode (mode1),
         .sftr (sftr1),
         .pix  (pix1[c*CW +: CW]),
         .acc  (acc1[c*AW +: AW]),
         .res  (res[c*AW +: AW])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v2      <= 1'b0;
         out_pix <= '0;
      end else if (s2_adv) begin
         v2 <= v1;
         if (v1) out_pix <= res;
      end
   end

   // clr wins over a coincident output handshake; that beat is not counted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pix_cnt    <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (clr) begin
            pix_cnt <= '0;
         end else if (out_hs) begin
            if (pix_cnt == frame_len - CNTW'(1)) begin
               pix_cnt    <= '0;
               frame_done <= 1'b1;
            end else begin
               pix_cnt <= pix_cnt + CNTW'(1);
            end
         end
      end
   end

endmodule
